// File: rtl/uart_tx_arbiter_if.sv
// Producer/serializer bus for uart_tx_arbiter.
// slave: the arbiter side; master: the producers plus serializer side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_data, tx_start, tx_busy, grant_id
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_data, tx_start, tx_busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 serializer between NUM_REQ byte producers.
// Grants one pending requester, launches its byte with a 1-cycle strobe, then
// holds off further launches until the frame (plus optional gap) has elapsed.
// Build option: UART_ARB_FIXED_PRI_EN selects lowest-index fixed priority
// instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned FRAME_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 0
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
    localparam int unsigned GCW   = 8;

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_e;

    state_e             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               tx_busy_q;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GCW-1:0]     gcnt_q, gcnt_d;
`ifndef UART_ARB_FIXED_PRI_EN
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    cand;
    logic [NUM_REQ-1:0] ready_c;
    logic [7:0]         req_bytes [NUM_REQ];

    // Unpack the flat data bus into per-requester bytes
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = bus.req_data[8*g +: 8];
    end

    // Winner search: first valid requester starting at the priority origin
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef UART_ARB_FIXED_PRI_EN
            cand = ID_W'(k);
`else
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
`endif
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        ready_c    = '0;
`ifndef UART_ARB_FIXED_PRI_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready_c    = NUM_REQ'(1) << win;
                    tx_data_d  = req_bytes[win];
                    tx_start_d = 1'b1;
                    grant_d    = win;
                    cnt_d      = CNT_W'(FRAME_CYCLES - 2);
                    state_d    = WAIT;
`ifndef UART_ARB_FIXED_PRI_EN
                    rr_ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        gcnt_d  = GCW'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            grant_q    <= '0;
            cnt_q      <= '0;
            gcnt_q     <= '0;
`ifndef UART_ARB_FIXED_PRI_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tx_busy_q  <= (state_d != IDLE);
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
`ifndef UART_ARB_FIXED_PRI_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // Accept pulse is same-cycle; forced low while reset is asserted
    assign bus.req_ready = ready_c & {NUM_REQ{reset}};
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: one instance with no gap,
// one with a 3-cycle gap between frames.
module tb_uart_tx_arbiter;
`ifdef UART_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if #(.NUM_REQ(4)) if0 ();
    uart_tx_arbiter_if #(.NUM_REQ(4)) if1 ();

    uart_tx_arbiter #(.NUM_REQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    uart_tx_arbiter #(.NUM_REQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the selected instance pulses tx_start; returns its cycle
    task automatic wait_start(input int which, output int t);
        bit seen;
        seen = 1'b0;
        t = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if ((which == 0) ? if0.tx_start : if1.tx_start) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        check("start_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && if0.tx_busy; i++) step();
        check("idle_reached", 32'(if0.tx_busy), 32'd0);
    endtask

    initial begin
        int t, tp, busy_n, bad, n3, exp_g;
        reset = 1'b0;
        if0.req_valid = '0; if0.req_data = '0;
        if1.req_valid = '0; if1.req_data = '0;
        step(); step();

        // Reset state
        check("rst_ready", 32'(if0.req_ready), 32'd0);
        check("rst_start", 32'(if0.tx_start), 32'd0);
        check("rst_data",  32'(if0.tx_data),  32'd0);
        check("rst_busy",  32'(if0.tx_busy),  32'd0);
        check("rst_grant", 32'(if0.grant_id), 32'd0);
        reset = 1'b1;

        // Single request on requester 1
        step();
        if0.req_valid = 4'b0010;
        if0.req_data[15:8] = 8'hA5;
        #1;
        check("t2_ready", 32'(if0.req_ready), 32'h2);
        check("t2_busy_pre", 32'(if0.tx_busy), 32'd0);
        step();
        if0.req_valid = '0;
        check("t2_start", 32'(if0.tx_start), 32'd1);
        check("t2_data",  32'(if0.tx_data),  32'hA5);
        check("t2_grant", 32'(if0.grant_id), 32'd1);
        check("t2_busy",  32'(if0.tx_busy),  32'd1);
        busy_n = 1;
        step();
        check("t2_start_once", 32'(if0.tx_start), 32'd0);
        for (int i = 0; i < 20 && if0.tx_busy; i++) begin
            busy_n++;
            step();
        end
        check("t2_busy_cycles", 32'(busy_n), 32'd9);

        // Async reset mid-WAIT right after the strobe, with a request pending
        if0.req_valid = 4'b0001;
        if0.req_data[7:0] = 8'h3C;
        #1;
        check("t1_ready_acc", 32'(if0.req_ready), 32'h1);
        step();
        if0.req_valid = 4'b1000;
        check("t1_start", 32'(if0.tx_start), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t1_async_start", 32'(if0.tx_start), 32'd0);
        check("t1_async_data",  32'(if0.tx_data),  32'd0);
        check("t1_async_busy",  32'(if0.tx_busy),  32'd0);
        check("t1_async_grant", 32'(if0.grant_id), 32'd0);
        check("t1_async_ready", 32'(if0.req_ready), 32'd0);
        step();
        if0.req_valid = '0;
        reset = 1'b1;

        // All four requesters continuously valid
        if0.req_valid = 4'b1111;
        if0.req_data = 32'h1312_1110;
        tp = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start(0, t);
            exp_g = FIXED ? 0 : (k % 4);
            check("t3_grant", 32'(if0.grant_id), 32'(exp_g));
            check("t3_data",  32'(if0.tx_data),  32'(8'h10 + exp_g));
            if (k > 0) check("t3_period", 32'(t - tp), 32'd10);
            tp = t;
        end
        if0.req_valid = '0;
        wait_idle();

        // Request rising during WAIT waits for the first IDLE cycle
        if0.req_valid = 4'b0001;
        if0.req_data[7:0] = 8'h55;
        #1;
        check("t5_ready0", 32'(if0.req_ready), 32'h1);
        step();
        if0.req_valid = 4'b0100;
        if0.req_data[23:16] = 8'hC3;
        #1;
        check("t5_start0", 32'(if0.tx_start), 32'd1);
        bad = 0;
        for (int i = 0; i < 20 && if0.tx_busy; i++) begin
            if (if0.req_ready != 4'b0000) bad++;
            step();
        end
        check("t5_no_ready_wait", 32'(bad), 32'd0);
        check("t5_idle", 32'(if0.tx_busy), 32'd0);
        check("t5_ready_idle", 32'(if0.req_ready), 32'h4);
        step();
        if0.req_valid = '0;
        check("t5_start", 32'(if0.tx_start), 32'd1);
        check("t5_data",  32'(if0.tx_data),  32'hC3);
        check("t5_grant", 32'(if0.grant_id), 32'd2);
        wait_idle();

        // Requesters 0 and 3 held from a fresh reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        if0.req_valid = 4'b1001;
        if0.req_data = 32'hB300_00A0;
        n3 = 0;
        for (int k = 0; k < 4; k++) begin
            wait_start(0, t);
            exp_g = FIXED ? 0 : ((k % 2 == 1) ? 3 : 0);
            check("t6_grant", 32'(if0.grant_id), 32'(exp_g));
            if (if0.grant_id == 2'd3) n3++;
        end
        check("t6_n3", 32'(n3), FIXED ? 32'd0 : 32'd2);
        if0.req_valid = '0;
        wait_idle();

        // Gap instance: back-to-back requester 0
        if1.req_valid = 4'b0001;
        if1.req_data[7:0] = 8'h7E;
        wait_start(1, tp);
        wait_start(1, t);
        check("t4_period1", 32'(t - tp), 32'd13);
        tp = t;
        wait_start(1, t);
        check("t4_period2", 32'(t - tp), 32'd13);
        check("t4_data", 32'(if1.tx_data), 32'h7E);
        if1.req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
